// File: rtl/sorteio_classes.sv
// Role-assignment datapath: latches a seed, fills the role table with the
// fixed role mix, shuffles it with an LFSR-driven Fisher-Yates pass and
// presents the class of the selected player through a registered output.
module sorteio_classes #(
  parameter int          N_JOGADORES  = 8,
  parameter int          N_LOBOS      = 2,
  parameter logic [7:0]  SEED_DEFAULT = 8'hA5,
  localparam int         W            = $clog2(N_JOGADORES)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic [7:0]   seed_in,
  input  logic         e_seed,
  input  logic [W-1:0] jogador_idx,
  input  logic         mostra_classe,
  output logic [1:0]   classe_out,
  output logic         classe_valida,
  output logic         pronto,
  output logic [2:0]   db_estado
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CARREGA  = 3'd1,
    PREENCHE = 3'd2,
    SORTEIA  = 3'd3,
    TROCA    = 3'd4,
    PRONTO   = 3'd5
  } estado_t;

  estado_t        estado;
  estado_t        estado_prox;
  logic [7:0]     semente;
  logic [7:0]     lfsr;
  logic [7:0]     lfsr_prox;
  logic [1:0]     tabela [N_JOGADORES];
  logic [W-1:0]   i;
  logic [W-1:0]   j;
  logic [3:0]     tentativas;
  logic [W-1:0]   candidato;
  logic           sorteio_ok;
  logic           idx_ok;
  logic           mostrar;

  // Candidate uses the LFSR value before this cycle's step.
  assign candidato  = lfsr[W-1:0];
  assign lfsr_prox  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign sorteio_ok = (candidato <= i) || (tentativas == 4'd15);
  assign idx_ok     = {1'b0, jogador_idx} < (W+1)'(N_JOGADORES);
  assign mostrar    = mostra_classe & pronto & idx_ok;
  assign db_estado  = estado;

  // State register; zera clears synchronously with the same effect as reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     estado <= OCIOSO;
    else if (zera) estado <= OCIOSO;
    else           estado <= estado_prox;
  end

  // Next-state logic; e_seed restarts from CARREGA in any legal state.
  // NOTE: estado_prox gets a default before the case so no latch is inferred.
  always_comb begin
    estado_prox = OCIOSO;
    case (estado)
      OCIOSO:   estado_prox = OCIOSO;
      CARREGA:  estado_prox = PREENCHE;
      PREENCHE: estado_prox = SORTEIA;
      SORTEIA:  estado_prox = sorteio_ok ? TROCA : SORTEIA;
      TROCA:    estado_prox = (i == W'(1)) ? PRONTO : SORTEIA;
      PRONTO:   estado_prox = PRONTO;
      default:  estado_prox = OCIOSO;
    endcase
    if (e_seed && (estado <= PRONTO)) estado_prox = CARREGA;
  end

  // Shuffle datapath: seed latch, LFSR, role table, loop index and retries.
  // NOTE: the role table is reset too, because after reset or zera every
  // entry must read as aldeao, so it cannot be mapped to a reset-less RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      semente    <= '0;
      lfsr       <= '0;
      i          <= '0;
      j          <= '0;
      tentativas <= '0;
      pronto     <= 1'b0;
      for (int k = 0; k < N_JOGADORES; k++) tabela[k] <= 2'd0;
    end else if (zera) begin
      semente    <= '0;
      lfsr       <= '0;
      i          <= '0;
      j          <= '0;
      tentativas <= '0;
      pronto     <= 1'b0;
      for (int k = 0; k < N_JOGADORES; k++) tabela[k] <= 2'd0;
    end else if (e_seed) begin
      semente <= seed_in;
    end else begin
      case (estado)
        CARREGA: begin
          lfsr   <= (semente == 8'd0) ? SEED_DEFAULT : semente;
          pronto <= 1'b0;
        end
        PREENCHE: begin
          for (int k = 0; k < N_JOGADORES; k++) begin
            if (k < N_LOBOS)           tabela[k] <= 2'd1;
            else if (k == N_LOBOS)     tabela[k] <= 2'd2;
            else if (k == N_LOBOS + 1) tabela[k] <= 2'd3;
            else                       tabela[k] <= 2'd0;
          end
          i          <= W'(N_JOGADORES - 1);
          tentativas <= '0;
        end
        SORTEIA: begin
          lfsr <= lfsr_prox;
          if (candidato <= i)            j <= candidato;
          else if (tentativas == 4'd15) j <= i;
          else                           tentativas <= tentativas + 4'd1;
        end
        TROCA: begin
          tabela[i] <= tabela[j];
          tabela[j] <= tabela[i];
          if (i == W'(1)) begin
            pronto <= 1'b1;
          end else begin
            i          <= i - W'(1);
            tentativas <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered display output, one cycle behind the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      classe_valida <= 1'b0;
      classe_out    <= 2'd0;
    end else if (zera) begin
      classe_valida <= 1'b0;
      classe_out    <= 2'd0;
    end else begin
      classe_valida <= mostrar;
      classe_out    <= mostrar ? tabela[jogador_idx] : 2'd0;
    end
  end

endmodule
